// File: rtl/uart_rx_ext.sv
// UART receiver with 8x oversampling, 3-sample majority vote, optional parity,
// 1/2 stop bits, break detection and an AXI-Stream master output.
module uart_rx_ext #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tuser,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   input  logic                  rxd,
   input  logic [15:0]           prescale,
   input  logic [1:0]            parity_mode,
   input  logic                  stop_bits,
   output logic                  busy,
   output logic                  overrun_error,
   output logic                  frame_error,
   output logic                  parity_error,
   output logic                  break_detect
);

   localparam int unsigned BIT_W = 4;
   localparam int unsigned PRE_W = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } state_e;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // rxd is asynchronous; the chain presets to idle-high so reset never looks like a start edge
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '1;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
   end

   assign rx_c = sync_q[SYNC_STAGES-1];

   state_e                state_q, state_d;
   logic                  rx_prev_q, rx_prev_d;
   logic [PRE_W-1:0]      cnt_q, cnt_d;
   logic [2:0]            sub_q, sub_d;
   logic [2:0]            smp_q, smp_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic                  par_q, par_d;
   logic                  zero_q, zero_d;
   logic                  serr_q, serr_d;
   logic                  stop_idx_q, stop_idx_d;
   logic [2:0]            hi_q, hi_d;
   logic [PRE_W-1:0]      presc_q, presc_d;
   logic [1:0]            pmode_q, pmode_d;
   logic                  stop2_q, stop2_d;
   logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
   logic                  tuser_q, tuser_d;
   logic                  tvalid_q, tvalid_d;
   logic                  busy_q, busy_d;
   logic                  ovr_q, ovr_d;
   logic                  ferr_q, ferr_d;
   logic                  perr_q, perr_d;
   logic                  brk_q, brk_d;

   logic tick_c, end5_c, end7_c, maj_c, fmaj_c;
   logic par_en_c, pbit_c, perr_c, stop_err_c, all_zero_c;

   // next-state, datapath and output decode
   always_comb begin
      state_d    = state_q;
      rx_prev_d  = rx_c;
      cnt_d      = cnt_q;
      sub_d      = sub_q;
      smp_d      = smp_q;
      bit_d      = bit_q;
      shreg_d    = shreg_q;
      par_d      = par_q;
      zero_d     = zero_q;
      serr_d     = serr_q;
      stop_idx_d = stop_idx_q;
      hi_d       = hi_q;
      presc_d    = presc_q;
      pmode_d    = pmode_q;
      stop2_d    = stop2_q;
      tdata_d    = tdata_q;
      tuser_d    = tuser_q;
      tvalid_d   = tvalid_q;
      ovr_d      = 1'b0;
      ferr_d     = 1'b0;
      perr_d     = 1'b0;
      brk_d      = 1'b0;

      tick_c     = (cnt_q == '0);
      end5_c     = tick_c && (sub_q == 3'd5);
      end7_c     = tick_c && (sub_q == 3'd7);
      maj_c      = maj3(smp_q[0], smp_q[1], smp_q[2]);
      fmaj_c     = maj3(smp_q[0], smp_q[1], rx_c);
      par_en_c   = pmode_q[0] ^ pmode_q[1];
      pbit_c     = (^shreg_q) ^ (pmode_q == 2'd2);
      perr_c     = par_en_c & (par_q != pbit_c);
      stop_err_c = serr_q | ~fmaj_c;
      // with one stop bit the final stop sample is also the first stop bit
      all_zero_c = zero_q & (stop2_q | ~fmaj_c);

      if (tick_c) begin
         cnt_d = presc_q - 16'd1;
         sub_d = sub_q + 3'd1;
         case (sub_q)
            3'd3:    smp_d[0] = rx_c;
            3'd4:    smp_d[1] = rx_c;
            3'd5:    smp_d[2] = rx_c;
            default: ;
         endcase
      end else begin
         cnt_d = cnt_q - 16'd1;
      end

      if (tvalid_q && m_axis_tready) tvalid_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (rx_prev_q && !rx_c) begin
               state_d    = S_START;
               cnt_d      = '0;
               sub_d      = '0;
               presc_d    = (prescale == '0) ? 16'd1 : prescale;
               pmode_d    = parity_mode;
               stop2_d    = stop_bits;
               bit_d      = '0;
               zero_d     = 1'b1;
               serr_d     = 1'b0;
               stop_idx_d = 1'b0;
               par_d      = 1'b0;
            end
         end
         S_START: begin
            if (end7_c) state_d = maj_c ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (end7_c) begin
               shreg_d = {maj_c, shreg_q[DATA_WIDTH-1:1]};
               zero_d  = zero_q & ~maj_c;
               bit_d   = bit_q + 4'd1;
               if (bit_q == BIT_W'(DATA_WIDTH - 1)) state_d = par_en_c ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            if (end7_c) begin
               par_d   = maj_c;
               zero_d  = zero_q & ~maj_c;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (stop2_q && !stop_idx_q) begin
               if (end7_c) begin
                  zero_d     = zero_q & ~maj_c;
                  serr_d     = ~maj_c;
                  stop_idx_d = 1'b1;
               end
            end else if (end5_c) begin
               // decide mid final stop bit so the next start edge is never missed
               if (!stop_err_c) begin
                  if (!tvalid_q || m_axis_tready) begin
                     tdata_d  = shreg_q;
                     tuser_d  = perr_c;
                     tvalid_d = 1'b1;
                  end else begin
                     ovr_d = 1'b1;
                  end
                  perr_d  = perr_c;
                  state_d = S_IDLE;
               end else if (all_zero_c) begin
                  brk_d   = 1'b1;
                  hi_d    = '0;
                  state_d = S_BREAK;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_BREAK: begin
            if (!rx_c) begin
               hi_d = '0;
            end else if (tick_c) begin
               if (hi_q == 3'd7) state_d = S_IDLE;
               else              hi_d    = hi_q + 3'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         rx_prev_q  <= 1'b1;
         cnt_q      <= '0;
         sub_q      <= '0;
         smp_q      <= '0;
         bit_q      <= '0;
         shreg_q    <= '0;
         par_q      <= 1'b0;
         zero_q     <= 1'b0;
         serr_q     <= 1'b0;
         stop_idx_q <= 1'b0;
         hi_q       <= '0;
         presc_q    <= 16'd1;
         pmode_q    <= '0;
         stop2_q    <= 1'b0;
         tdata_q    <= '0;
         tuser_q    <= 1'b0;
         tvalid_q   <= 1'b0;
         busy_q     <= 1'b0;
         ovr_q      <= 1'b0;
         ferr_q     <= 1'b0;
         perr_q     <= 1'b0;
         brk_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rx_prev_q  <= rx_prev_d;
         cnt_q      <= cnt_d;
         sub_q      <= sub_d;
         smp_q      <= smp_d;
         bit_q      <= bit_d;
         shreg_q    <= shreg_d;
         par_q      <= par_d;
         zero_q     <= zero_d;
         serr_q     <= serr_d;
         stop_idx_q <= stop_idx_d;
         hi_q       <= hi_d;
         presc_q    <= presc_d;
         pmode_q    <= pmode_d;
         stop2_q    <= stop2_d;
         tdata_q    <= tdata_d;
         tuser_q    <= tuser_d;
         tvalid_q   <= tvalid_d;
         busy_q     <= busy_d;
         ovr_q      <= ovr_d;
         ferr_q     <= ferr_d;
         perr_q     <= perr_d;
         brk_q      <= brk_d;
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tuser  = tuser_q;
   assign m_axis_tvalid = tvalid_q;
   assign busy          = busy_q;
   assign overrun_error = ovr_q;
   assign frame_error   = ferr_q;
   assign parity_error  = perr_q;
   assign break_detect  = brk_q;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: an 8-bit instance and a 9-bit instance share
// clock, reset and config; each has its own serial line and sink.
module tb_uart_rx_ext;

   localparam int BIT_CLK = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] prescale;
   logic [1:0]  pm;
   logic        sb;
   logic        rxd8, rxd9, rdy8, rdy9;
   logic [7:0]  tdata8;
   logic [8:0]  tdata9;
   logic        tuser8, tvalid8, busy8, ovr8, ferr8, perr8, brk8;
   logic        tuser9, tvalid9, busy9, ovr9, ferr9, perr9, brk9;

   int n_chk = 0, n_err = 0;
   int ovr8_n = 0, ferr8_n = 0, perr8_n = 0, brk8_n = 0;
   int ovr9_n = 0, ferr9_n = 0, perr9_n = 0, brk9_n = 0;

   always #5 clk = ~clk;

   uart_rx_ext #(.DATA_WIDTH(8), .SYNC_STAGES(2)) u_dut8 (
      .clk(clk), .rst_n(rst_n),
      .m_axis_tdata(tdata8), .m_axis_tuser(tuser8), .m_axis_tvalid(tvalid8),
      .m_axis_tready(rdy8), .rxd(rxd8), .prescale(prescale), .parity_mode(pm),
      .stop_bits(sb), .busy(busy8), .overrun_error(ovr8), .frame_error(ferr8),
      .parity_error(perr8), .break_detect(brk8)
   );

   uart_rx_ext #(.DATA_WIDTH(9), .SYNC_STAGES(2)) u_dut9 (
      .clk(clk), .rst_n(rst_n),
      .m_axis_tdata(tdata9), .m_axis_tuser(tuser9), .m_axis_tvalid(tvalid9),
      .m_axis_tready(rdy9), .rxd(rxd9), .prescale(prescale), .parity_mode(pm),
      .stop_bits(sb), .busy(busy9), .overrun_error(ovr9), .frame_error(ferr9),
      .parity_error(perr9), .break_detect(brk9)
   );

   // pulse cycle counters; a single 1-cycle pulse adds exactly one
   always @(negedge clk) begin
      if (ovr8)  ovr8_n++;
      if (ferr8) ferr8_n++;
      if (perr8) perr8_n++;
      if (brk8)  brk8_n++;
      if (ovr9)  ovr9_n++;
      if (ferr9) ferr9_n++;
      if (perr9) perr9_n++;
      if (brk9)  brk9_n++;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic vld(input bit d9);
      return d9 ? tvalid9 : tvalid8;
   endfunction

   task automatic drive(input bit d9, input logic v);
      @(negedge clk);
      if (d9) rxd9 = v;
      else    rxd8 = v;
      repeat (BIT_CLK - 1) @(negedge clk);
   endtask

   task automatic send_frame(input bit d9, input logic [8:0] data, input int nbits,
                             input bit par_en, input logic par, input logic st1,
                             input bit two, input logic st2);
      drive(d9, 1'b0);
      for (int i = 0; i < nbits; i++) drive(d9, data[i]);
      if (par_en) drive(d9, par);
      drive(d9, st1);
      if (two) drive(d9, st2);
      drive(d9, 1'b1);
   endtask

   task automatic pop(input bit d9, input logic [8:0] exp_d, input logic exp_u, input string tag);
      int n = 0;
      while (!vld(d9) && n < 64) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_valid"}, vld(d9), 1);
      chk({tag, "_data"}, d9 ? tdata9 : {1'b0, tdata8}, exp_d);
      chk({tag, "_user"}, d9 ? tuser9 : tuser8, exp_u);
      if (d9) rdy9 = 1'b1;
      else    rdy8 = 1'b1;
      @(negedge clk);
      rdy8 = 1'b0;
      rdy9 = 1'b0;
      chk({tag, "_clr"}, vld(d9), 0);
   endtask

   initial begin
      rst_n    = 1'b0;
      rxd8     = 1'b1;
      rxd9     = 1'b1;
      rdy8     = 1'b0;
      rdy9     = 1'b0;
      prescale = 16'd2;
      pm       = 2'd0;
      sb       = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_flags8", {tvalid8, tuser8, busy8, ovr8, ferr8, perr8, brk8}, 0);
      chk("rst_tdata8", tdata8, 0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      // 8N1 0xA5, held until accepted
      send_frame(0, 9'h0A5, 8, 0, 1'b0, 1'b1, 0, 1'b1);
      chk("a5_valid", tvalid8, 1);
      repeat (5) @(negedge clk);
      chk("a5_hold_valid", tvalid8, 1);
      chk("a5_hold_data", tdata8, 8'hA5);
      pop(0, 9'h0A5, 1'b0, "a5");
      chk("a5_no_err", ovr8_n + ferr8_n + perr8_n + brk8_n, 0);

      // even parity, 0x3C has even weight so a 1 parity bit is wrong
      pm = 2'd1;
      send_frame(0, 9'h03C, 8, 1, 1'b1, 1'b1, 0, 1'b1);
      pop(0, 9'h03C, 1'b1, "par");
      chk("par_pulse", perr8_n, 1);
      pm = 2'd0;

      // 4-clk glitch is rejected as a false start
      @(negedge clk);
      rxd8 = 1'b0;
      repeat (4) @(negedge clk);
      rxd8 = 1'b1;
      chk("glitch_busy", busy8, 1);
      repeat (16) @(negedge clk);
      chk("glitch_idle", busy8, 0);
      chk("glitch_valid", tvalid8, 0);
      chk("glitch_no_err", ovr8_n + ferr8_n + perr8_n + brk8_n, 1);

      // overrun: second word dropped while first is unaccepted
      send_frame(0, 9'h011, 8, 0, 1'b0, 1'b1, 0, 1'b1);
      send_frame(0, 9'h022, 8, 0, 1'b0, 1'b1, 0, 1'b1);
      chk("ovr_pulse", ovr8_n, 1);
      chk("ovr_keep", tdata8, 8'h11);
      pop(0, 9'h011, 1'b0, "ovr");

      // break: line low for 12 bit times
      @(negedge clk);
      rxd8 = 1'b0;
      repeat (12 * BIT_CLK) @(negedge clk);
      rxd8 = 1'b1;
      chk("brk_pulse", brk8_n, 1);
      chk("brk_no_ferr", ferr8_n, 0);
      chk("brk_no_valid", tvalid8, 0);
      repeat (8) @(negedge clk);
      chk("brk_busy", busy8, 1);
      repeat (24) @(negedge clk);
      chk("brk_done", busy8, 0);
      send_frame(0, 9'h05A, 8, 0, 1'b0, 1'b1, 0, 1'b1);
      pop(0, 9'h05A, 1'b0, "after_brk");

      // 9-bit, odd parity, two stop bits: 0x1FF has odd weight so parity bit 0
      pm = 2'd2;
      sb = 1'b1;
      send_frame(1, 9'h1FF, 9, 1, 1'b0, 1'b1, 1, 1'b1);
      pop(1, 9'h1FF, 1'b0, "w9");
      chk("w9_no_err", ovr9_n + ferr9_n + perr9_n + brk9_n, 0);
      send_frame(1, 9'h1FF, 9, 1, 1'b0, 1'b1, 1, 1'b0);
      chk("w9_ferr", ferr9_n, 1);
      chk("w9_ferr_valid", tvalid9, 0);
      chk("w9_ferr_brk", brk9_n, 0);

      // reset mid-frame
      @(negedge clk);
      rxd9 = 1'b0;
      repeat (4 * BIT_CLK) @(negedge clk);
      chk("mid_busy", busy9, 1);
      rst_n = 1'b0;
      rxd9  = 1'b1;
      repeat (3) @(negedge clk);
      chk("mid_rst_flags", {tvalid9, tuser9, busy9, ovr9, ferr9, perr9, brk9}, 0);
      chk("mid_rst_tdata", tdata9, 0);
      rst_n = 1'b1;
      repeat (2 * BIT_CLK) @(negedge clk);
      // 0x0A5 has even weight so odd parity bit is 1
      send_frame(1, 9'h0A5, 9, 1, 1'b1, 1'b1, 1, 1'b1);
      pop(1, 9'h0A5, 1'b0, "post_rst");

      chk("tot_ovr8", ovr8_n, 1);
      chk("tot_ferr8", ferr8_n, 0);
      chk("tot_perr8", perr8_n, 1);
      chk("tot_brk8", brk8_n, 1);
      chk("tot_9", {8'(ovr9_n), 8'(ferr9_n), 8'(perr9_n), 8'(brk9_n)}, 32'h0001_0000);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
